// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and helpers for the memory access unit
package mem_access_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ALIGN  = 2'b01;
    localparam logic [1:0] ERR_SLVERR = 2'b10;
    localparam logic [1:0] ERR_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_DEF  = 4'b0011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

    // dword_ok is 0 on a 32-bit bus, which makes every SZ_D access a trap
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a,
                                           input logic dword_ok);
        logic r;
        case (sz)
            SZ_B:    r = 1'b0;
            SZ_H:    r = a[0];
            SZ_W:    r = (a[1:0] != 2'b00);
            default: r = !dword_ok || (a != 3'b000);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - single-beat AXI4 read/write channel bundle
interface mem_access_unit_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [7:0]        arlen;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arlock;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [7:0]        awlen;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awlock;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arsize, arburst, arlen, arcache, arprot, arlock, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awsize, awburst, awlen, awcache, awprot, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arsize, arburst, arlen, arcache, arprot, arlock, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awsize, awburst, awlen, awcache, awprot, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, strobes and load extraction/extension
module mem_lane_align #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [OFF_W-1:0]    off,
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   ld_data
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] shifted;
    int                nbytes;
    int                nbits;
    logic              sign;

    assign wdata   = st_data << {off, 3'b000};
    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        nbytes = 1 << size;
        // an oversized access only reaches here when it has already trapped
        if (nbytes > STRB_W) begin
            nbytes = STRB_W;
        end
        nbits = nbytes * 8;

        wstrb = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wstrb[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
        end

        sign = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) begin
                sign = shifted[i];
            end
        end

        ld_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ld_data[i] = (i < nbits) ? shifted[i] : (sign & ~is_unsigned);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit issuing single-beat AXI4 accesses
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [4:0]        rd_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] data,
    output logic [4:0]        rd_out,
    output logic [3:0]        wselector,
    mem_access_unit_if.master axi
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [1:0]        size_q,     size_d;
    logic              uns_q,      uns_d;
    logic              store_q,    store_d;
    logic [4:0]        rd_q,       rd_d;
    logic [DATA_W-1:0] st_data_q,  st_data_d;
    logic              arvalid_q,  arvalid_d;
    logic              rready_q,   rready_d;
    logic              awvalid_q,  awvalid_d;
    logic              wvalid_q,   wvalid_d;
    logic              bready_q,   bready_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [DATA_W-1:0] data_q,     data_d;

    logic [DATA_W-1:0] lane_wdata;
    logic [STRB_W-1:0] lane_wstrb;
    logic [DATA_W-1:0] lane_ld;
    logic              accept;

    mem_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_lane (
        .off        (addr_q[OFF_W-1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .st_data    (st_data_q),
        .rdata      (axi.rdata),
        .wdata      (lane_wdata),
        .wstrb      (lane_wstrb),
        .ld_data    (lane_ld)
    );

    // FIN is not busy, so a request can be taken back-to-back with the completion
    assign accept = enable && (state_q == ST_IDLE || state_q == ST_FIN);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        store_d    = store_q;
        rd_d       = rd_q;
        st_data_d  = st_data_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        err_code_d = err_code_q;
        data_d     = data_q;

        case (state_q)
            ST_RD: begin
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                end
                if (rready_q && axi.rvalid) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    state_d   = ST_FIN;
                    if (axi.rresp[1]) begin
                        err_code_d = axi.rresp;
                        data_d     = '0;
                    end else begin
                        data_d     = lane_ld;
                    end
                end
            end
            ST_WR: begin
                if (awvalid_q && axi.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                end
                if (bready_q && axi.bvalid) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    state_d   = ST_FIN;
                    if (axi.bresp[1]) begin
                        err_code_d = axi.bresp;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
            end
        endcase

        if (accept) begin
            addr_d     = addr;
            size_d     = size;
            uns_d      = is_unsigned;
            store_d    = is_store;
            rd_d       = rd_in;
            st_data_d  = st_data;
            err_code_d = ERR_NONE;
            data_d     = '0;
            if (is_misaligned(size, addr[2:0], 1'(DATA_W == 64))) begin
                err_code_d = ERR_ALIGN;
                state_d    = ST_FIN;
            end else if (is_store) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                bready_d  = 1'b1;
                state_d   = ST_WR;
            end else begin
                arvalid_d = 1'b1;
                rready_d  = 1'b1;
                state_d   = ST_RD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            store_q    <= 1'b0;
            rd_q       <= '0;
            st_data_q  <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            err_code_q <= ERR_NONE;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            st_data_q  <= st_data_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            err_code_q <= err_code_d;
            data_q     <= data_d;
        end
    end

    assign busy      = (state_q == ST_RD) || (state_q == ST_WR);
    assign done      = (state_q == ST_FIN);
    assign err       = done && (err_code_q != ERR_NONE);
    assign err_code  = err_code_q;
    assign data      = data_q;
    assign rd_out    = rd_q;
    assign wselector = (done && !store_q && err_code_q == ERR_NONE) ? 4'b0010 : 4'b0000;

    assign axi.araddr  = addr_q;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = addr_q;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = lane_wdata;
    assign axi.wstrb   = wvalid_q ? lane_wstrb : '0;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    assign axi.arburst = BURST_INCR;
    assign axi.awburst = BURST_INCR;
    assign axi.arlen   = 8'd0;
    assign axi.awlen   = 8'd0;
    assign axi.arcache = CACHE_DEF;
    assign axi.awcache = CACHE_DEF;
    assign axi.arprot  = 3'b000;
    assign axi.awprot  = 3'b000;
    assign axi.arlock  = 1'b0;
    assign axi.awlock  = 1'b0;
    assign axi.wlast   = 1'b1;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              is_store = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              is_unsigned = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic [4:0]        rd_in = '0;
    logic              busy, done, err;
    logic [1:0]        err_code;
    logic [DATA_W-1:0] data;
    logic [4:0]        rd_out;
    logic [3:0]        wselector;

    mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .is_store(is_store), .size(size),
        .is_unsigned(is_unsigned), .addr(addr), .st_data(st_data), .rd_in(rd_in),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .data(data),
        .rd_out(rd_out), .wselector(wselector), .axi(axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ec;
        logic [31:0] d;
        logic [3:0]  ws;
        logic [4:0]  rd;
        bit          is_ld;
    } exp_t;

    exp_t        expq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cyc;
    logic [31:0] last_data, seen_wdata;
    logic [1:0]  last_ec;
    logic [3:0]  last_ws, seen_wstrb;
    logic [2:0]  seen_arsize;
    logic [14:0] seen_awaddr;
    logic        last_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_mis(input int sz, input int a);
        int nb = 1 << sz;
        return (sz == 3) || ((a % nb) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdv, input int a, input int sz, input bit uns);
        int          off = a % 4;
        int          nb  = 1 << sz;
        logic [63:0] mask, v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = ({32'd0, rdv} >> (8 * off)) & mask;
        if (!uns && v[8 * nb - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_strb(input int a, input int sz);
        logic [7:0] m;
        m = 8'(((1 << (1 << sz)) - 1) << (a % 4));
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] sd, input int a);
        logic [63:0] v;
        v = {32'd0, sd} << (8 * (a % 4));
        return v[31:0];
    endfunction

    // Scoreboard: every completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (expq.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("err_code", err_code, e.ec);
                chk("err", err, e.ec != 2'b00);
                chk("wselector", wselector, e.ws);
                chk("rd_out", rd_out, e.rd);
                if (e.is_ld && e.ec != 2'b01) chk("data", data, e.d);
            end
        end
    end

    // Starts at a point away from the clock edge; returns at the negedge of the done cycle.
    task automatic do_txn(input bit st, input int sz, input bit uns, input int a,
                          input logic [31:0] sd, input logic [31:0] rdv, input logic [1:0] resp,
                          input int d1, input int d2, input int d3);
        exp_t       e;
        bit         mis, h_a, h_w, fin;
        int         cyc, c_a, c_w;
        logic [4:0] rdv5;
        mis     = m_mis(sz, a);
        rdv5    = 5'($urandom);
        e.ec    = mis ? 2'b01 : (resp[1] ? resp : 2'b00);
        e.is_ld = !st;
        e.rd    = rdv5;
        e.d     = (!st && !mis && !resp[1]) ? m_load(rdv, a, sz, uns) : 32'd0;
        e.ws    = (!st && e.ec == 2'b00) ? 4'b0010 : 4'b0000;
        expq.push_back(e);
        enable = 1'b1; is_store = st; size = sz[1:0]; is_unsigned = uns;
        addr = a[14:0]; st_data = sd; rd_in = rdv5;
        @(posedge clk); #1;
        enable = 1'b0;
        cyc = 1; h_a = 0; h_w = 0; c_a = 0; c_w = 0; fin = 0;
        if (mis) begin
            @(negedge clk);
            chk("align_done", done, 1);
            chk("align_no_bus", axi.arvalid | axi.awvalid | axi.wvalid, 0);
            done_cyc = 1; last_data = data; last_ec = err_code; last_ws = wselector; last_err = err;
            return;
        end
        while (!fin && cyc < 60) begin
            enable = 1'($urandom); is_store = 1'($urandom); size = 2'($urandom);
            addr = 15'($urandom); st_data = $urandom; rd_in = 5'($urandom);
            if (!st) begin
                axi.arready = !h_a && cyc >= 1 + d1;
                axi.rvalid  = h_a && cyc >= c_a + 1 + d3;
                axi.rdata   = axi.rvalid ? rdv : $urandom;
                axi.rresp   = axi.rvalid ? resp : 2'($urandom);
            end else begin
                axi.awready = !h_a && cyc >= 1 + d1;
                axi.wready  = !h_w && cyc >= 1 + d2;
                axi.bvalid  = h_a && h_w && cyc >= ((c_a > c_w) ? c_a : c_w) + 1 + d3;
                axi.bresp   = resp;
            end
            @(negedge clk);
            chk("busy", busy, 1);
            if (!st) begin
                chk("arvalid", axi.arvalid, !h_a);
                if (!h_a) begin
                    chk("araddr", axi.araddr, a[14:0]);
                    chk("arsize", axi.arsize, {1'b0, sz[1:0]});
                    seen_arsize = axi.arsize;
                end
                chk("rready", axi.rready, 1);
                if (axi.arvalid && axi.arready) begin h_a = 1; c_a = cyc; end
                if (axi.rvalid && axi.rready) fin = 1;
            end else begin
                chk("awvalid", axi.awvalid, !h_a);
                chk("wvalid", axi.wvalid, !h_w);
                if (!h_a) begin
                    chk("awaddr", axi.awaddr, a[14:0]);
                    chk("awsize", axi.awsize, {1'b0, sz[1:0]});
                    seen_awaddr = axi.awaddr;
                end
                if (!h_w) begin
                    chk("wdata", axi.wdata, m_wdata(sd, a));
                    chk("wstrb", axi.wstrb, m_strb(a, sz));
                    seen_wdata = axi.wdata; seen_wstrb = axi.wstrb;
                end
                chk("bready", axi.bready, 1);
                if (axi.awvalid && axi.awready) begin h_a = 1; c_a = cyc; end
                if (axi.wvalid && axi.wready) begin h_w = 1; c_w = cyc; end
                if (axi.bvalid && axi.bready) fin = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        enable = 1'b0;
        if (!fin) chk("handshake_timeout", 0, 1);
        @(negedge clk);
        chk("done_at_fin", done, 1);
        chk("idle_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, busy}, 0);
        done_cyc = cyc; last_data = data; last_ec = err_code; last_ws = wselector; last_err = err;
    endtask

    initial begin
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {busy, done, err, err_code, wselector, rd_out}, 0);
        chk("rst_data", data, 0);
        chk("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
        chk("rst_addr", {axi.araddr, axi.awaddr}, 0);
        chk("rst_w", {axi.wdata, axi.wstrb}, 0);
        chk("const_ar", {axi.arburst, axi.arlen, axi.arcache, axi.arprot, axi.arlock},
            {2'b01, 8'd0, 4'b0011, 3'b000, 1'b0});
        chk("const_aw_w", {axi.awburst, axi.awlen, axi.awcache, axi.awprot, axi.awlock, axi.wlast},
            {2'b01, 8'd0, 4'b0011, 3'b000, 1'b0, 1'b1});
        rst = 1'b0;
        @(negedge clk);

        do_txn(0, 0, 0, 32'h3, 32'h0, 32'h80FF_1234, 2'b00, 0, 0, 0);
        chk("lb_data", last_data, 32'hFFFF_FF80);
        chk("lb_wsel", last_ws, 4'b0010);
        chk("lb_arsize", seen_arsize, 3'b000);
        chk("lb_latency", done_cyc, 3);

        do_txn(0, 1, 1, 32'h2, 32'h0, 32'h8001_0000, 2'b00, 0, 0, 0);
        chk("lhu_data", last_data, 32'h0000_8001);

        do_txn(1, 1, 0, 32'h6, 32'h0000_ABCD, 32'h0, 2'b00, 0, 0, 0);
        chk("sh_wdata", seen_wdata, 32'hABCD_0000);
        chk("sh_wstrb", seen_wstrb, 4'b1100);
        chk("sh_awaddr", seen_awaddr, 15'h0006);
        chk("sh_latency", done_cyc, 3);

        do_txn(1, 2, 0, 32'h10, 32'h1234_5678, 32'h0, 2'b00, 3, 0, 0);
        chk("stall_latency", done_cyc, 6);

        do_txn(0, 2, 0, 32'h2, 32'h0, 32'h0, 2'b00, 0, 0, 0);
        chk("lw_mis_latency", done_cyc, 1);
        chk("lw_mis_code", {last_err, last_ec}, 3'b101);

        do_txn(0, 2, 0, 32'h4, 32'h0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0);
        chk("slverr_code", last_ec, 2'b10);
        chk("slverr_data", last_data, 0);
        chk("slverr_wsel", last_ws, 4'b0000);

        // Reset while arvalid is outstanding, then a fresh load right behind it.
        enable = 1'b1; is_store = 0; size = 2'b10; addr = 15'h20; rd_in = 5'd7;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_arvalid", axi.arvalid, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", {axi.arvalid, axi.rready, busy, done}, 0);
        do_txn(0, 2, 1, 32'h40, 32'h0, 32'hCAFE_F00D, 2'b00, 0, 0, 0);
        chk("post_rst_data", last_data, 32'hCAFE_F00D);

        for (int t = 0; t < 150; t++) begin
            int a, sz, gap;
            logic [1:0] resp;
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 32767);
            if ($urandom_range(0, 1) == 1) a = a & ~((1 << sz) - 1);
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, resp,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
